// File: rtl/bemicrocv_pkg.sv
// Shared constants and types for the BeMicro CV LED pattern engine.
package bemicrocv_pkg;

   // Display modes, as selected by the DIP switches
   typedef enum logic [1:0] {
      MODE_BIN     = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_RING    = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   // Direction of travel for scan position and breathing duty
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Speed setting width and the number of settings it encodes
   localparam int SPEED_W    = 2;
   localparam int NUM_SPEEDS = 1 << SPEED_W;

   // Register width able to hold 0..n-1, never narrower than one bit
   function automatic int w_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// a single-cycle press pulse on each accepted 1->0 transition.
module debounce
   import bemicrocv_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic in_n,
   output logic level_n,
   output logic press
);

   localparam int CNT_W = w_of(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_reg;
   logic             level_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             differ;
   logic             settle;

   // A sample differing from the accepted level is a candidate change;
   // the DEB_CYCLES-th consecutive one is accepted.
   assign differ = (sync_reg[1] != level_reg);
   assign settle = differ && (cnt_reg == CNT_LAST);

   // Bring the raw button into the clock domain
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], in_n};
      end
   end

   // Count consecutive differing samples; any agreeing sample restarts
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         level_reg <= 1'b1;
      end else if (!differ) begin
         cnt_reg <= '0;
      end else if (settle) begin
         cnt_reg   <= '0;
         level_reg <= sync_reg[1];
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign level_n = level_reg;
   // Press fires in the same cycle the level is accepted low; release is silent
   assign press   = settle && !sync_reg[1];

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaler with speed control, debounced step/speed
// buttons and four display modes driving active-low LEDs.
module led_pattern_gen
   import bemicrocv_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 10,
   parameter int LED_W      = 8,
   parameter int DEB_CYCLES = 1_000_000,
   parameter int PWM_BITS   = 8
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             run_en,
   input  logic             btn_step_n,
   input  logic             btn_speed_n,
   output logic [LED_W-1:0] led_n,
   output logic             tick
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = w_of(DIV);
   localparam int POS_W = w_of(LED_W);
   localparam logic [PRE_W-1:0]    PRE_INIT = PRE_W'(DIV - 1);
   localparam logic [POS_W-1:0]    POS_LAST = POS_W'(LED_W - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

   genvar gi;

   logic [PRE_W-1:0]    presc_reg;
   logic                tick_reg;
   logic [SPEED_W-1:0]  speed_reg;
   logic [PRE_W-1:0]    reload_tbl [NUM_SPEEDS];

   mode_t               mode_reg;
   logic [LED_W-1:0]    count_reg;
   logic [POS_W-1:0]    pos_reg;
   dir_t                dir_reg;
   logic [PWM_BITS-1:0] duty_reg;
   logic [PWM_BITS-1:0] pwm_cnt_reg;
   logic [LED_W-1:0]    led_reg;

   logic                step_level_n;
   logic                speed_level_n;
   logic                step_press;
   logic                speed_press;
   logic                mode_chg;
   logic                adv;
   logic [LED_W-1:0]    onehot;
   logic [LED_W-1:0]    led_on;

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
      .clk_50  (clk_50),
      .rst_n   (rst_n),
      .in_n    (btn_step_n),
      .level_n (step_level_n),
      .press   (step_press)
   );

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
      .clk_50  (clk_50),
      .rst_n   (rst_n),
      .in_n    (btn_speed_n),
      .level_n (speed_level_n),
      .press   (speed_press)
   );

   // Reload value per speed setting: period DIV >> speed, floored at one clock
   for (gi = 0; gi < NUM_SPEEDS; gi++) begin : g_reload
      localparam int SHIFTED = DIV >> gi;
      assign reload_tbl[gi] = (SHIFTED > 0) ? PRE_W'(SHIFTED - 1) : '0;
   end

   // Down-counting prescaler; speed is sampled only when reloading
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg <= PRE_INIT;
         tick_reg  <= 1'b0;
      end else if (presc_reg == '0) begin
         presc_reg <= reload_tbl[speed_reg];
         tick_reg  <= 1'b1;
      end else begin
         presc_reg <= presc_reg - 1'b1;
         tick_reg  <= 1'b0;
      end
   end

   // Speed button cycles through the four settings
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         speed_reg <= '0;
      end else if (speed_press) begin
         speed_reg <= speed_reg + 1'b1;
      end
   end

   // One advance per cycle at most; a pending mode change swallows it
   assign mode_chg = (mode_reg != mode_t'(mode));
   assign adv      = !mode_chg && ((run_en && tick_reg) || (!run_en && step_press));

   // Pattern state machine: restarts on mode change, otherwise steps on adv
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg  <= MODE_BIN;
         count_reg <= '0;
         pos_reg   <= '0;
         dir_reg   <= DIR_UP;
         duty_reg  <= '0;
      end else if (mode_chg) begin
         mode_reg  <= mode_t'(mode);
         count_reg <= '0;
         pos_reg   <= '0;
         dir_reg   <= DIR_UP;
         duty_reg  <= '0;
      end else if (adv) begin
         case (mode_reg)
            MODE_BIN: begin
               count_reg <= count_reg + 1'b1;
            end
            MODE_SCAN: begin
               // bounce off the ends without repeating the end position
               if (dir_reg == DIR_UP) begin
                  if (pos_reg == POS_LAST) begin
                     dir_reg <= DIR_DOWN;
                     pos_reg <= POS_LAST - 1'b1;
                  end else begin
                     pos_reg <= pos_reg + 1'b1;
                  end
               end else begin
                  if (pos_reg == '0) begin
                     dir_reg <= DIR_UP;
                     pos_reg <= POS_W'(1);
                  end else begin
                     pos_reg <= pos_reg - 1'b1;
                  end
               end
            end
            MODE_RING: begin
               pos_reg <= (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
            end
            MODE_BREATHE: begin
               // duty ramps up and down, turning around on the same advance
               if (dir_reg == DIR_UP) begin
                  if (duty_reg == DUTY_MAX) begin
                     dir_reg  <= DIR_DOWN;
                     duty_reg <= DUTY_MAX - 1'b1;
                  end else begin
                     duty_reg <= duty_reg + 1'b1;
                  end
               end else begin
                  if (duty_reg == '0) begin
                     dir_reg  <= DIR_UP;
                     duty_reg <= PWM_BITS'(1);
                  end else begin
                     duty_reg <= duty_reg - 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Free-running PWM phase for breathing mode
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
   end

   // Position decode for the one-hot modes
   for (gi = 0; gi < LED_W; gi++) begin : g_onehot
      assign onehot[gi] = (pos_reg == POS_W'(gi));
   end

   // Select the lit-LED image for the current mode
   always_comb begin
      led_on = '0;
      case (mode_reg)
         MODE_BIN:     led_on = count_reg;
         MODE_SCAN:    led_on = onehot;
         MODE_RING:    led_on = onehot;
         MODE_BREATHE: led_on = {LED_W{pwm_cnt_reg < duty_reg}};
         default:      led_on = '0;
      endcase
   end

   // Registered active-low LED drive
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         led_reg <= '1;
      end else begin
         led_reg <= ~led_on;
      end
   end

   assign led_n = led_reg;
   assign tick  = tick_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a small, fast configuration.
module tb_led_pattern_gen;

   logic       clk_50 = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       run_en;
   logic       btn_step_n;
   logic       btn_speed_n;
   logic [3:0] led_n;
   logic       tick;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q [$];

   int scan_idx [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
   int ring_idx [5] = '{1, 2, 3, 0, 1};
   int spd_per  [3] = '{2, 1, 10};

   led_pattern_gen #(
      .CLK_HZ     (100),
      .TICK_HZ    (10),
      .LED_W      (4),
      .DEB_CYCLES (4),
      .PWM_BITS   (4)
   ) dut (
      .clk_50      (clk_50),
      .rst_n       (rst_n),
      .mode        (mode),
      .run_en      (run_en),
      .btn_step_n  (btn_step_n),
      .btn_speed_n (btn_speed_n),
      .led_n       (led_n),
      .tick        (tick)
   );

   always #5 clk_50 = ~clk_50;

   always @(posedge clk_50) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s = %0h (cyc %0d)", tag, got, cyc);
      end
   endtask

   task automatic sb_chk(input string tag, input logic [31:0] got);
      logic [31:0] e;
      e = exp_q.pop_front();
      chk(tag, got, e);
   endtask

   // Wait for the next tick pulse (at least one clock), bounded
   task automatic wait_tick(output int at);
      at = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk_50);
         if (tick) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("tick_timeout", 32'(tick), 32'd1);
   endtask

   task automatic press_speed();
      btn_speed_n = 1'b0;
      repeat (6) @(negedge clk_50);
      btn_speed_n = 1'b1;
      repeat (8) @(negedge clk_50);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, t, t0, t1, t2, a, b, lit, mixed;
      logic [3:0] e4;

      rst_n = 1'b0; mode = 2'd0; run_en = 1'b1;
      btn_step_n = 1'b1; btn_speed_n = 1'b1;
      repeat (3) @(negedge clk_50);
      chk("rst_led", 32'(led_n), 32'hF);
      chk("rst_tick", 32'(tick), 32'd0);
      rst_n = 1'b1;
      r = cyc;

      // binary mode, free-running
      for (int k = 1; k <= 16; k++) begin
         e4 = ~4'(k);
         exp_q.push_back(32'(e4));
      end
      t = r;
      for (int k = 1; k <= 16; k++) begin
         wait_tick(t1);
         if (k == 1) chk("first_tick", t1 - r, 10);
         else        chk("bin_period", t1 - t, 10);
         t = t1;
         repeat (2) @(negedge clk_50);
         sb_chk("bin_led", 32'(led_n));
      end

      // scan mode
      mode = 2'd1;
      repeat (2) @(negedge clk_50);
      chk("scan_start", 32'(led_n), 32'hE);
      foreach (scan_idx[i]) begin
         e4 = ~(4'b0001 << scan_idx[i]);
         exp_q.push_back(32'(e4));
      end
      foreach (scan_idx[i]) begin
         wait_tick(t);
         repeat (2) @(negedge clk_50);
         sb_chk("scan_led", 32'(led_n));
      end

      // ring mode
      mode = 2'd2;
      repeat (2) @(negedge clk_50);
      chk("ring_start", 32'(led_n), 32'hE);
      foreach (ring_idx[i]) begin
         e4 = ~(4'b0001 << ring_idx[i]);
         exp_q.push_back(32'(e4));
      end
      foreach (ring_idx[i]) begin
         wait_tick(t);
         repeat (2) @(negedge clk_50);
         sb_chk("ring_led", 32'(led_n));
      end

      // single-step with debounce
      mode = 2'd0; run_en = 1'b0;
      repeat (3) @(negedge clk_50);
      chk("step_idle", 32'(led_n), 32'hF);
      btn_step_n = 1'b0;
      repeat (3) @(negedge clk_50);
      btn_step_n = 1'b1;
      repeat (20) @(negedge clk_50);
      chk("step_glitch", 32'(led_n), 32'hF);
      btn_step_n = 1'b0;
      repeat (6) @(negedge clk_50);
      btn_step_n = 1'b1;
      chk("step_early", 32'(led_n), 32'hF);
      @(negedge clk_50);
      chk("step_adv", 32'(led_n), 32'hE);
      repeat (30) @(negedge clk_50);
      chk("step_once", 32'(led_n), 32'hE);

      // step press ignored while free-running
      wait_tick(t);
      @(negedge clk_50);
      run_en = 1'b1;
      wait_tick(t);
      repeat (2) @(negedge clk_50);
      chk("run_tick", 32'(led_n), 32'hD);
      btn_step_n = 1'b0;
      repeat (6) @(negedge clk_50);
      btn_step_n = 1'b1;
      @(negedge clk_50);
      chk("run_step_ign", 32'(led_n), 32'hD);
      wait_tick(t1);
      chk("run_phase", t1 - t, 10);
      repeat (2) @(negedge clk_50);
      chk("run_tick2", 32'(led_n), 32'hC);

      // speed: change applies at the next reload only
      wait_tick(t0);
      btn_speed_n = 1'b0;
      repeat (6) @(negedge clk_50);
      btn_speed_n = 1'b1;
      wait_tick(t1);
      chk("spd_keep", t1 - t0, 10);
      wait_tick(t2);
      chk("spd_p1", t2 - t1, 5);
      foreach (spd_per[i]) begin
         exp_q.push_back(32'(spd_per[i]));
         exp_q.push_back(32'(spd_per[i]));
      end
      foreach (spd_per[i]) begin
         press_speed();
         wait_tick(a);
         for (int j = 0; j < 2; j++) begin
            wait_tick(b);
            sb_chk("spd_period", b - a);
            a = b;
         end
      end

      // breathe mode: ramp duty to 5 then hold it
      mode = 2'd3;
      for (int k = 0; k < 5; k++) wait_tick(t);
      @(negedge clk_50);
      run_en = 1'b0;
      repeat (2) @(negedge clk_50);
      lit = 0; mixed = 0;
      repeat (16) begin
         @(negedge clk_50);
         if (led_n == 4'h0)      lit++;
         else if (led_n != 4'hF) mixed++;
      end
      chk("breathe_lit", lit, 5);
      chk("breathe_mixed", mixed, 0);

      // mode switch mid-ramp restarts pattern but not the prescaler
      run_en = 1'b1;
      wait_tick(t);
      repeat (3) @(negedge clk_50);
      mode = 2'd0;
      repeat (2) @(negedge clk_50);
      chk("sw_clear", 32'(led_n), 32'hF);
      wait_tick(t1);
      chk("sw_phase", t1 - t, 10);
      repeat (2) @(negedge clk_50);
      chk("sw_first", 32'(led_n), 32'hE);

      // asynchronous reset in the middle of a tick
      wait_tick(t);
      rst_n = 1'b0;
      #1;
      chk("arst_tick", 32'(tick), 32'd0);
      chk("arst_led", 32'(led_n), 32'hF);
      @(negedge clk_50);
      rst_n = 1'b1;
      r = cyc;
      wait_tick(t);
      chk("arst_first_tick", t - r, 10);
      repeat (2) @(negedge clk_50);
      chk("arst_count", 32'(led_n), 32'hE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
